// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// 8N1 UART receiver (LSB first, idle-high line) with a one-entry output buffer
// and ready/valid hand-off to the consumer.
//
// The raw line is synchronized, and a start condition is detected on the first
// low level seen in IDLE. One down-counter then times the middle of every bit.
// A completed byte goes into the output buffer, or raises overrun if the buffer
// is still occupied. A low stop bit raises frame_error once. The receiver then
// waits for the line to return high before it looks for the next start bit.
//
// Ports
//   clock          system clock, all state on the rising edge
//   reset_n        asynchronous active-low reset
//   uart_rx        asynchronous serial input
//   cycles_per_bit bit period in clock cycles, clamped to >= 4, latched per frame
//   rx_data        received byte, stable while rx_valid = 1
//   rx_valid       rx_data holds an unconsumed byte
//   rx_ready       consumer accepts rx_data when rx_valid & rx_ready
//   frame_error    one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: byte completed while the buffer was full
//
// FSM states
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | line idle, waiting for rx low (start edge)
//   START     | half-period wait, re-check start bit at its middle
//   DATA      | sampling 8 data bits, LSB first
//   STOP      | sampling stop bit, deliver byte or flag framing error
//   WAIT_HIGH | after a framing error, wait for the line to return high
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        uart_rx,
    input  logic [15:0] cycles_per_bit,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        frame_error,
    output logic        overrun
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("uart_receiver: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. Its flops reset to 1 so that reset looks like an idle
    // line and cannot produce a false start bit.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Bit timing. The period is clamped to at least 4 cycles so that the
    // half-period wait and the sample spacing stay meaningful.
    // -------------------------------------------------------------------------
    logic [15:0] period_eff;

    assign period_eff = (cycles_per_bit < 16'd4) ? 16'd4 : cycles_per_bit;

    state_t      state_q;
    logic [15:0] period_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        sample;

    // The counter reaching zero marks the middle of the current bit.
    assign sample = (cnt_q == 16'd0);

    // -------------------------------------------------------------------------
    // Receive FSM and output buffer
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            period_q    <= 16'd4;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;

            // Consumption. A byte completing in the same cycle overrides this
            // below and keeps rx_valid high.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx) begin
                        // Latch the period for the whole frame, then wait
                        // half a bit to land in the middle of the start bit.
                        period_q <= period_eff;
                        cnt_q    <= period_eff >> 1;
                        state_q  <= S_START;
                    end
                end

                S_START: begin
                    if (sample) begin
                        cnt_q <= period_q - 16'd1;
                        if (rx) begin
                            // The line went high again: it was a glitch.
                            state_q <= S_IDLE;
                        end else begin
                            bit_idx_q <= 3'd0;
                            state_q   <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                S_DATA: begin
                    if (sample) begin
                        cnt_q     <= period_q - 16'd1;
                        shift_q   <= {rx, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                S_STOP: begin
                    if (sample) begin
                        cnt_q <= period_q - 16'd1;
                        if (rx) begin
                            state_q <= S_IDLE;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_q;
                                rx_valid <= 1'b1;
                            end else begin
                                // Buffer full and not draining: keep the old
                                // byte and drop the new one.
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end

                S_WAIT_HIGH: begin
                    // A break holds the line low. Waiting for high here means
                    // one break raises exactly one frame_error.
                    if (rx) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] cycles_per_bit = 16'd434;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_error;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int valid_cyc = 0;
    int v0;

    always #5 clock = ~clock;

    uart_receiver #(.SYNC_STAGES(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .uart_rx        (uart_rx),
        .cycles_per_bit (cycles_per_bit),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .frame_error    (frame_error),
        .overrun        (overrun)
    );

    // Pulse monitors, sampled away from the active edge.
    always @(negedge clock) begin
        if (frame_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (frame_error === 1'b1 && overrun === 1'b1) both_cnt++;
        if (rx_valid === 1'b1) valid_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then move 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Start bit plus 8 data bits, each p cycles. Leaves the line on data bit 7.
    task automatic drive_bits(input logic [7:0] d, input int p);
        uart_rx = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(p);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input int p);
        drive_bits(d, p);
        uart_rx = 1'b1;
        tick(p);
        tick(8);
    endtask

    // Frame with an exact latency check. The stop sample edge is p/2 + 4 edges
    // after the end of the data bits. cpb_mid is applied mid-frame and must
    // have no effect on this frame.
    task automatic recv_timed(input logic [7:0] d, input int p, input logic [15:0] cpb_mid);
        drive_bits(d, p);
        cycles_per_bit = cpb_mid;
        uart_rx = 1'b1;
        tick(p / 2 + 3);
        check("valid_before_stop_sample", rx_valid, 1'b0);
        tick(1);
        check("valid_after_stop_sample", rx_valid, 1'b1);
        check("data_after_stop_sample", rx_data, d);
        tick(p);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_frame_error", frame_error, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset_n = 1'b1;
        tick(5);

        // 0xA5 at 434 cycles/bit with exact timing; cycles_per_bit changed mid-frame
        recv_timed(8'hA5, 434, 16'd50);
        cycles_per_bit = 16'd434;
        check("a5_no_frame_error", fe_cnt, 0);
        check("a5_no_overrun", ov_cnt, 0);
        consume();
        check("a5_consumed", rx_valid, 1'b0);

        // 100-cycle glitch on the idle line, then 0x3C
        uart_rx = 1'b0;
        tick(100);
        uart_rx = 1'b1;
        tick(2 * 434);
        check("glitch_no_valid", rx_valid, 1'b0);
        check("glitch_no_frame_error", fe_cnt, 0);
        drive_frame(8'h3C, 434);
        check("after_glitch_valid", rx_valid, 1'b1);
        check("after_glitch_data", rx_data, 8'h3C);
        consume();

        // 0x55 with a low stop bit, line held low 20 bit periods
        v0 = valid_cyc;
        drive_bits(8'h55, 434);
        uart_rx = 1'b0;
        tick(20 * 434);
        uart_rx = 1'b1;
        tick(2 * 434);
        check("break_one_frame_error", fe_cnt, 1);
        check("break_no_valid", valid_cyc - v0, 0);
        check("break_data_unchanged", rx_data, 8'h3C);

        // Overrun: 0x11 then 0x22 without consuming
        drive_frame(8'h11, 434);
        drive_frame(8'h22, 434);
        check("overrun_data_kept", rx_data, 8'h11);
        check("overrun_valid", rx_valid, 1'b1);
        check("overrun_one_pulse", ov_cnt, 1);
        consume();
        check("overrun_consumed", rx_valid, 1'b0);

        // Consume in the exact cycle the second byte completes
        drive_frame(8'h11, 434);
        check("simul_first_data", rx_data, 8'h11);
        drive_bits(8'h22, 434);
        uart_rx = 1'b1;
        tick(434 / 2 + 3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("simul_valid_stays", rx_valid, 1'b1);
        check("simul_data_new", rx_data, 8'h22);
        check("simul_no_overrun", ov_cnt, 1);
        tick(434);
        consume();
        check("simul_consumed", rx_valid, 1'b0);

        // cycles_per_bit=2 is clamped to 4; 0xFF at a 4-cycle bit period
        cycles_per_bit = 16'd2;
        recv_timed(8'hFF, 4, 16'd2);
        check("clamp_no_frame_error", fe_cnt, 1);

        // Reset during bit 3 of a frame, with 0xFF still buffered
        cycles_per_bit = 16'd16;
        uart_rx = 1'b0;
        tick(16 * 4);
        uart_rx = 1'b1;
        tick(8);
        reset_n = 1'b0;
        #1;
        check("midreset_valid", rx_valid, 1'b0);
        check("midreset_data", rx_data, 8'h00);
        check("midreset_frame_error", frame_error, 1'b0);
        check("midreset_overrun", overrun, 1'b0);
        tick(2);
        reset_n = 1'b1;
        v0 = valid_cyc;
        tick(16 * 6);
        check("midreset_no_valid", valid_cyc - v0, 0);
        check("midreset_no_frame_error", fe_cnt, 1);
        check("midreset_no_overrun", ov_cnt, 1);
        drive_frame(8'h81, 16);
        check("after_reset_valid", rx_valid, 1'b1);
        check("after_reset_data", rx_data, 8'h81);

        check("never_both_flags", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
